seq_generator: RTL and testbench

- Serial pattern transmitter. It is the driving end of the serial bit line that seq_detector monitors.
- Captures a PAT_W-bit pattern on a start pulse and shifts it out MSB-first, one bit per clk, on x.
- Supports a programmable frame length, a repeat count and idle gap cycles between frames.
- Used as a stimulus source and link driver for the detector (default pattern 10010).

---
 rtl/seq_generator.sv | 188 ++++++++++++++++++
 tb/tb_seq_generator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_generator.sv
// seq_generator: serial pattern transmitter.
// Captures a pattern on start and shifts it out MSB-first on x, with a
// programmable frame length, repeat count and idle gap between frames.
module seq_generator #(
    parameter int   PAT_W    = 5,
    parameter int   LEN_W    = 3,
    parameter int   CNT_W    = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_TWO = LEN_W'(2);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state_q, state_d;

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic x_q, x_d;
    logic x_valid_q, x_valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [LEN_W-1:0] len_eff;

    // Selects one pattern bit by a LEN_W-wide index without a width-mismatched part select.
    function automatic logic pick_bit(input logic [PAT_W-1:0] pat,
                                      input logic [LEN_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (idx == LEN_W'(i)) begin
                b = pat[i];
            end
        end
        return b;
    endfunction

    // Clamp the requested length: zero or anything beyond the pattern width sends the whole pattern.
    always_comb begin
        len_eff = len;
        if ((len == '0) || (len > PAT_LEN)) begin
            len_eff = PAT_LEN;
        end
    end

    // Next-state and registered-output logic; abort overrides every transition.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        gap_d     = gap_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        x_d       = IDLE_LVL;
        x_valid_d = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    pat_d     = pattern;
                    len_d     = len_eff;
                    gap_d     = gap;
                    bit_cnt_d = len_eff;
                    rep_cnt_d = reps;
                    x_d       = pick_bit(pattern, len_eff - LEN_ONE);
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == LEN_ONE) begin
                    if (rep_cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (gap_q == '0) begin
                        bit_cnt_d = len_q;
                        rep_cnt_d = rep_cnt_q - CNT_ONE;
                        x_d       = pick_bit(pat_q, len_q - LEN_ONE);
                        x_valid_d = 1'b1;
                    end else begin
                        gap_cnt_d = gap_q;
                        rep_cnt_d = rep_cnt_q - CNT_ONE;
                        state_d   = GAP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - LEN_ONE;
                    x_d       = pick_bit(pat_q, bit_cnt_q - LEN_TWO);
                    x_valid_d = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_ONE) begin
                    bit_cnt_d = len_q;
                    x_d       = pick_bit(pat_q, len_q - LEN_ONE);
                    x_valid_d = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d   = IDLE;
            x_d       = IDLE_LVL;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    // State, captured configuration, counters and outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            x_q       <= IDLE_LVL;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// Testbench for seq_generator: expected bit/done events with their cycle
// numbers are queued by the driver and consumed by an independent monitor.
module tb_seq_generator;

    localparam int   PAT_W    = 5;
    localparam int   LEN_W    = 3;
    localparam int   CNT_W    = 4;
    localparam int   GAP_W    = 4;
    localparam logic IDLE_LVL = 1'b0;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    seq_generator #(
        .PAT_W   (PAT_W),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W),
        .IDLE_LVL(IDLE_LVL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .pattern(pattern),
        .len    (len),
        .reps   (reps),
        .gap    (gap),
        .abort  (abort),
        .x      (x),
        .x_valid(x_valid),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_done;
        logic        bit_val;
        logic [31:0] cyc;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mdl_q[$];
    ev_t         mon_ev;
    int unsigned cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    // Free-running cycle number; the value seen after edge T is T.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: list every bit and the done pulse with the cycle it must appear in.
    task automatic model(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] ln,
                         input logic [CNT_W-1:0] rp, input logic [GAP_W-1:0] gp,
                         input int unsigned t0, output int unsigned done_cyc);
        int          eff;
        int unsigned t;
        ev_t         e;
        eff = ((ln == 0) || (int'(ln) > PAT_W)) ? PAT_W : int'(ln);
        mdl_q.delete();
        t = t0;
        for (int f = 0; f <= int'(rp); f++) begin
            for (int b = eff - 1; b >= 0; b--) begin
                e.is_done = 1'b0;
                e.bit_val = pat[b];
                e.cyc     = t;
                mdl_q.push_back(e);
                t++;
            end
            if (f < int'(rp)) t += int'(gp);
        end
        e.is_done = 1'b1;
        e.bit_val = 1'b0;
        e.cyc     = t;
        mdl_q.push_back(e);
        done_cyc = t;
    endtask

    // Monitor: every valid bit or done pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (x_valid || done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_output", {30'd0, x_valid, done}, 32'd0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    checkOutput("event_cycle", cyc, mon_ev.cyc);
                    checkOutput("event_is_done", done, mon_ev.is_done);
                    checkOutput("x_valid_vs_done", x_valid, !mon_ev.is_done);
                    if (!mon_ev.is_done) checkOutput("x_bit", x, mon_ev.bit_val);
                end
            end else begin
                checkOutput("idle_level", x, IDLE_LVL);
                if ((exp_q.size() != 0) && (exp_q[0].cyc <= cyc)) begin
                    mon_ev = exp_q.pop_front();
                    checkOutput("missing_output", 32'd0, 32'd1);
                end
            end
        end
    end

    // One transmission; abort_after>0 aborts on edge t0+abort_after, stray pulses start mid-run.
    task automatic applyStimulus(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] ln,
                                 input logic [CNT_W-1:0] rp, input logic [GAP_W-1:0] gp,
                                 input int abort_after, input bit stray);
        int unsigned t0, done_cyc, end_cyc, stop;
        @(negedge clk);
        t0 = cyc + 1;
        model(pat, ln, rp, gp, t0, done_cyc);
        if (abort_after > int'(done_cyc - t0)) abort_after = 0;
        if (abort_after > 0) begin
            stop    = t0 + abort_after;
            end_cyc = stop;
        end else begin
            stop    = 0;
            end_cyc = done_cyc + 1;
        end
        foreach (mdl_q[i]) begin
            if ((abort_after <= 0) || (mdl_q[i].cyc < stop)) exp_q.push_back(mdl_q[i]);
        end
        pattern = pat;
        len     = ln;
        reps    = rp;
        gap     = gp;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        pattern = PAT_W'($urandom);
        len     = LEN_W'($urandom);
        reps    = CNT_W'($urandom);
        gap     = GAP_W'($urandom);
        checkOutput("busy_after_start", busy, 1'b1);
        while (cyc < end_cyc) begin
            start = stray && (cyc == t0 + 1);
            abort = (abort_after > 0) && (cyc == stop - 1);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        checkOutput("busy_at_end", busy, 1'b0);
        checkOutput("done_at_end", done, 1'b0);
        checkOutput("pending_events", exp_q.size(), 32'd0);
    endtask

    // Reset asserted between edges during the gap must clear outputs without a clock.
    task automatic resetMidGap();
        int unsigned t0, done_cyc;
        @(negedge clk);
        t0 = cyc + 1;
        model(5'b10010, 3'd5, 4'd1, 4'd3, t0, done_cyc);
        foreach (mdl_q[i]) begin
            if (mdl_q[i].cyc < t0 + 6) exp_q.push_back(mdl_q[i]);
        end
        pattern = 5'b10010;
        len     = 3'd5;
        reps    = 4'd1;
        gap     = 4'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 6) @(negedge clk);
        checkOutput("busy_in_gap", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_x", x, IDLE_LVL);
        checkOutput("async_reset_x_valid", x_valid, 1'b0);
        checkOutput("async_reset_busy", busy, 1'b0);
        checkOutput("async_reset_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("pending_after_reset", exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int          ab;
        logic [PAT_W-1:0] rp_pat;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        gap     = '0;
        #12;
        checkOutput("reset_x", x, IDLE_LVL);
        checkOutput("reset_x_valid", x_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] single frame");
        applyStimulus(5'b10010, 3'd5, 4'd0, 4'd0, 0, 1'b0);
        $display("[TB] back-to-back frames");
        applyStimulus(5'b10010, 3'd5, 4'd2, 4'd0, 0, 1'b0);
        $display("[TB] frames with gap");
        applyStimulus(5'b10010, 3'd5, 4'd1, 4'd3, 0, 1'b0);
        $display("[TB] length clamp");
        applyStimulus(5'b10110, 3'd0, 4'd0, 4'd0, 0, 1'b0);
        applyStimulus(5'b10110, 3'd7, 4'd0, 4'd0, 0, 1'b0);
        applyStimulus(5'b10110, 3'd2, 4'd0, 4'd0, 0, 1'b0);
        applyStimulus(5'b10110, 3'd1, 4'd1, 4'd2, 0, 1'b1);
        $display("[TB] abort and stray start");
        applyStimulus(5'b10010, 3'd5, 4'd0, 4'd0, 0, 1'b1);
        applyStimulus(5'b10010, 3'd5, 4'd0, 4'd0, 3, 1'b1);

        $display("[TB] abort with start in idle");
        @(negedge clk);
        pattern = 5'b11111;
        len     = 3'd5;
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("idle_abort_start_busy", busy, 1'b0);
        checkOutput("idle_abort_start_valid", x_valid, 1'b0);
        @(negedge clk);
        checkOutput("idle_abort_start_busy2", busy, 1'b0);

        $display("[TB] async reset in gap");
        resetMidGap();
        applyStimulus(5'b10010, 3'd5, 4'd0, 4'd0, 0, 1'b0);

        $display("[TB] randomized transmissions");
        for (int n = 0; n < 40; n++) begin
            rp_pat = PAT_W'($urandom);
            ab     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 0;
            applyStimulus(rp_pat, LEN_W'($urandom_range(0, 7)), CNT_W'($urandom_range(0, 3)),
                          GAP_W'($urandom_range(0, 3)), ab, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
